// File: rtl/adder_pkg.sv
// Shared definitions for the adder family.
//
// SLICE_W is the slice width shared with the combinational 8-bit conditional
// adder datapath. The multicycle wide adder reuses it so that both blocks agree
// on the slice granularity. state_t is the 2-bit state encoding of the
// multicycle wide adder FSM.
package adder_pkg;

  localparam int SLICE_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_t;

endpackage : adder_pkg

// File: rtl/slice_add.sv
// Combinational W-bit adder with carry-in and carry-out.
//
// Ports:
//   a, b  : W-bit addends
//   cin   : carry into bit 0
//   s     : W-bit sum, modulo 2^W
//   cout  : carry out of bit W-1
module slice_add
  import adder_pkg::*;
#(
  parameter int W = SLICE_W
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] s,
  output logic         cout
);

  // Zero-extend every operand to W+1 bits so the carry lands in the top bit.
  assign {cout, s} = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};

endmodule : slice_add

// File: rtl/multicycle_wide_adder.sv
// Sequential wide adder: adds two WIDTH-bit operands one SLICE-bit slice per
// cycle, least-significant slice first, with the inter-slice carry held in a
// flop. A single slice_add instance is time-multiplexed by the slice counter.
// WIDTH must be an integer multiple of SLICE.
//
// Ports:
//   clk, rst_n          : rising-edge clock, asynchronous active-low reset
//   in_valid / in_ready : operand handshake (a, b, cin)
//   out_valid/ out_ready: result handshake (sum, cout)
//   sum                 : a + b + cin modulo 2^WIDTH, held while out_valid=1
//   cout                : carry out of the top slice
//   busy                : high whenever the FSM is not idle
module multicycle_wide_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SLICE = SLICE_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int CNT_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [CNT_W-1:0] LAST_SLICE = CNT_W'(NSLICE - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, b_q, sum_q;
  logic             carry_q, cout_q;
  logic [CNT_W-1:0] cnt_q;

  logic [SLICE-1:0] a_slice, b_slice, s_slice;
  logic             c_slice;
  logic             accept, last_slice;

  assign accept     = (state_q == ST_IDLE) && in_valid;
  assign last_slice = (cnt_q == LAST_SLICE);

  assign a_slice = a_q[cnt_q*SLICE +: SLICE];
  assign b_slice = b_q[cnt_q*SLICE +: SLICE];

  slice_add #(.W(SLICE)) u_slice_add (
    .a    (a_slice),
    .b    (b_slice),
    .cin  (carry_q),
    .s    (s_slice),
    .cout (c_slice)
  );

  // Handshake outputs come straight from the state register, so neither
  // in_valid nor out_ready has a combinational path to a ready/valid output.
  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign busy      = (state_q != ST_IDLE);
  assign sum       = sum_q;
  assign cout      = cout_q;

  always_comb begin
    // NOTE: every always_comb target gets a default first, so no path through
    // the case leaves it unassigned and no latch is inferred.
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (in_valid)   state_d = ST_RUN;
      ST_RUN:  if (last_slice) state_d = ST_DONE;
      ST_DONE: if (out_ready)  state_d = ST_IDLE;
      default:                 state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Operand registers are reset too: they are only a few words wide, and a
  // defined value keeps the slice mux free of X after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      cnt_q   <= '0;
    end else if (accept) begin
      a_q     <= a;
      b_q     <= b;
      carry_q <= cin;
      cnt_q   <= '0;
    end else if (state_q == ST_RUN) begin
      sum_q[cnt_q*SLICE +: SLICE] <= s_slice;
      carry_q                     <= c_slice;
      cnt_q                       <= cnt_q + 1'b1;
      if (last_slice) cout_q <= c_slice;
    end
  end

endmodule : multicycle_wide_adder
